// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// 32-bit integer ALU for the RV32I datapath. It executes one of eight
// operations selected by sel. The result and its sign bit are registered, so
// each result appears one cycle after its operands.
//
// There is no handshake. A new operation is accepted on every rising clk edge.
// Only the rs1/rs2/sel values present at that edge matter.
//
// Ports
//   clk  in   1   system clock; all state updates on the rising edge
//   rst  in   1   synchronous, active-high reset; clears sal and MSB
//   rs1  in   32  operand A
//   rs2  in   32  operand B; rs2[4:0] is the shift amount for shifts
//   sel  in   3   operation select (see alu_op_e)
//   sal  out  32  registered result
//   MSB  out  1   registered sign bit of the result (always equals sal[31])
// ---------------------------------------------------------------------------
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  sel,
  output logic [31:0] sal,
  output logic        MSB
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SRA = 3'd7
  } alu_op_e;

  logic [31:0] sal_d, sal_q;
  logic        msb_d, msb_q;
  logic [4:0]  shamt;

  // Shifts only look at the low five bits. Larger rs2 values wrap modulo 32.
  assign shamt = rs2[4:0];

  // All eight encodings are covered, so the case needs no default.
  // ADD and SUB wrap silently; the carry and borrow are dropped.
  always_comb begin
    sal_d = 32'd0;
    unique case (alu_op_e'(sel))
      OP_ADD: sal_d = rs1 + rs2;
      OP_SUB: sal_d = rs1 - rs2;
      OP_AND: sal_d = rs1 & rs2;
      OP_OR:  sal_d = rs1 | rs2;
      OP_XOR: sal_d = rs1 ^ rs2;
      OP_SLL: sal_d = rs1 << shamt;
      OP_SRL: sal_d = rs1 >> shamt;
      OP_SRA: sal_d = $unsigned($signed(rs1) >>> shamt);
    endcase
    msb_d = sal_d[31];
  end

  // Reset takes priority over any operation presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sal_q <= 32'd0;
      msb_q <= 1'b0;
    end else begin
      sal_q <= sal_d;
      msb_q <= msb_d;
    end
  end

  assign sal = sal_q;
  assign MSB = msb_q;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
// Directed-vector bench for alu. Each vector is driven on the falling edge,
// and its hand-computed {MSB, sal} is queued. The result is popped and
// compared 1 ns after the next rising edge.
// ---------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  sel;
  logic [31:0] sal;
  logic        MSB;

  int n_checks;
  int n_errors;

  // Expected {MSB, sal}, pushed by the driver and popped by the scoreboard.
  logic [32:0] exp_q[$];

  alu dut (
    .clk (clk),
    .rst (rst),
    .rs1 (rs1),
    .rs2 (rs2),
    .sel (sel),
    .sal (sal),
    .MSB (MSB)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1;
    rs1 = 32'd0;
    rs2 = 32'd0;
    sel = 3'd0;
  end

  // Watchdog: the directed run is a few dozen cycles long.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver plus scoreboard step: present one op, then check it one cycle later.
  task automatic apply(input string tag, input logic r, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] s,
                       input logic [31:0] exp_sal, input logic exp_msb);
    logic [32:0] e;
    @(negedge clk);
    rst = r;
    rs1 = a;
    rs2 = b;
    sel = s;
    exp_q.push_back({exp_msb, exp_sal});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".sal"}, sal, e[31:0]);
    check({tag, ".msb"}, {31'd0, MSB}, {31'd0, e[32]});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset is held for two edges with a live ADD on the inputs.
    apply("rst0", 1'b1, 32'd5812, 32'd6352, 3'd0, 32'd0, 1'b0);
    apply("rst1", 1'b1, 32'd5812, 32'd6352, 3'd0, 32'd0, 1'b0);

    // Step through all eight ops with the same operands.
    // Shift amount is 0x18D0 & 0x1F = 16.
    apply("add", 1'b0, 32'd5812, 32'd6352, 3'd0, 32'd12164,     1'b0);
    apply("sub", 1'b0, 32'd5812, 32'd6352, 3'd1, 32'hFFFFFDE4,  1'b1);
    apply("and", 1'b0, 32'd5812, 32'd6352, 3'd2, 32'h00001090,  1'b0);
    apply("or",  1'b0, 32'd5812, 32'd6352, 3'd3, 32'h00001EF4,  1'b0);
    apply("xor", 1'b0, 32'd5812, 32'd6352, 3'd4, 32'h00000E64,  1'b0);
    apply("sll", 1'b0, 32'd5812, 32'd6352, 3'd5, 32'h16B40000,  1'b0);
    apply("srl", 1'b0, 32'd5812, 32'd6352, 3'd6, 32'h00000000,  1'b0);
    apply("sra", 1'b0, 32'd5812, 32'd6352, 3'd7, 32'h00000000,  1'b0);

    // Wraparound on ADD and SUB.
    apply("add_wrap", 1'b0, 32'hFFFFFFFF, 32'd1, 3'd0, 32'h00000000, 1'b0);
    apply("sub_wrap", 1'b0, 32'd0,        32'd1, 3'd1, 32'hFFFFFFFF, 1'b1);
    apply("add_ovf",  1'b0, 32'h7FFFFFFF, 32'd1, 3'd0, 32'h80000000, 1'b1);

    // Arithmetic versus logical right shift of a negative value.
    apply("sra_neg", 1'b0, 32'h80000000, 32'd4, 3'd7, 32'hF8000000, 1'b1);
    apply("srl_neg", 1'b0, 32'h80000000, 32'd4, 3'd6, 32'h08000000, 1'b0);

    // Shift-amount masking and edge amounts.
    apply("sll_mask", 1'b0, 32'd1,        32'h00000021, 3'd5, 32'h00000002, 1'b0);
    apply("sll_0",    1'b0, 32'hA5A5A5A5, 32'hFFFFFFE0, 3'd5, 32'hA5A5A5A5, 1'b1);
    apply("sll_31",   1'b0, 32'h00000003, 32'd31,       3'd5, 32'h80000000, 1'b1);
    apply("sra_31",   1'b0, 32'h80000000, 32'd31,       3'd7, 32'hFFFFFFFF, 1'b1);
    apply("srl_31",   1'b0, 32'h80000000, 32'd31,       3'd6, 32'h00000001, 1'b0);

    // Mid-stream reset: one rst edge clears the output, then results resume.
    apply("ms_xor", 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd4, 32'hFF00FF00, 1'b1);
    apply("ms_rst", 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd3, 32'h00000000, 1'b0);
    apply("ms_or",  1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd3, 32'hFFF0FFF0, 1'b1);
    apply("ms_and", 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd2, 32'h00F000F0, 1'b0);
    apply("ms_sub", 1'b0, 32'd100,      32'd58,       3'd1, 32'd42,       1'b0);

    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
